dcache_responder: RTL

- Direct-mapped, write-back, write-allocate data cache; the responder end of the datapath's data-side cache interface.
- Accepts dmemREN/dmemWEN/datomic requests from the pipeline's memory stage and returns dhit/dmemload.
- Fills and evicts 2-word blocks through the memory/cache-control port.
- Supports LL/SC via a link register.
- On datapath halt, flushes dirty lines, writes the hit count to HIT_ADDR, then raises flushed.

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_frame_array.sv | 28 ++
 rtl/dcache_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the datapath and caches.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/dcache_pkg.sv
// Data cache types: controller states, frame layout and default geometry.
package dcache_pkg;
    import cpu_types_pkg::word_t;

    localparam int          DC_SETS     = 8;
    localparam int          DC_WORDS    = 2;
    localparam int          DC_BLK_W    = 29;
    localparam logic [31:0] DC_HIT_ADDR = 32'h0000_3100;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        FETCH0,
        FETCH1,
        FLUSH,
        FWB0,
        FWB1,
        HITCNT,
        DONE
    } dcache_state_t;

    // tag holds the whole block address [31:3]; the index bits are
    // redundant but keep writeback addressing independent of SETS
    typedef struct packed {
        logic                       valid;
        logic                       dirty;
        logic [DC_BLK_W-1:0]        tag;
        word_t [DC_WORDS-1:0]       data;
    } dcache_frame_t;
endpackage

// File: rtl/dcache_frame_array.sv
// Direct-mapped frame storage: one combinational read port, one write port.
module dcache_frame_array
    import dcache_pkg::*;
#(
    parameter int SETS = DC_SETS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(SETS)-1:0] rd_idx,
    output dcache_frame_t           rd_frame,
    input  logic                    we,
    input  logic [$clog2(SETS)-1:0] wr_idx,
    input  dcache_frame_t           wr_frame
);
    dcache_frame_t frames [SETS];

    assign rd_frame = frames[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                frames[i] <= '0;
            end
        end else if (we) begin
            frames[wr_idx] <= wr_frame;
        end
    end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache with LL/SC link and halt-time flush.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int          SETS     = DC_SETS,
    parameter logic [31:0] HIT_ADDR = DC_HIT_ADDR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int IDX_W = $clog2(SETS);
    localparam int PTR_W = IDX_W + 1;

    dcache_state_t state, state_n;
    logic             armed;
    logic             miss_pending, miss_pending_n;
    logic [31:0]      hit_cnt, hit_cnt_n;
    logic             link_valid, link_valid_n;
    logic [29:0]      link_addr, link_addr_n;
    logic [31:0]      fill, fill_n;
    logic [PTR_W-1:0] ptr, ptr_n;

    logic [IDX_W-1:0]    idx, rd_idx;
    logic [DC_BLK_W-1:0] blk;
    logic [29:0]         word_addr;
    logic                off;
    logic                flush_mode;
    dcache_frame_t       fr, wr_frame;
    logic                we;

    logic req, is_sc, sc_fail, hit, miss;
    logic unused_addr_bits;

    assign unused_addr_bits = ^dmemaddr[1:0];

    assign idx       = dmemaddr[2+IDX_W:3];
    assign blk       = dmemaddr[31:3];
    assign word_addr = dmemaddr[31:2];
    assign off       = dmemaddr[2];

    assign flush_mode = (state == FLUSH) || (state == FWB0) ||
                        (state == FWB1);
    assign rd_idx = flush_mode ? ptr[IDX_W-1:0] : idx;

    dcache_frame_array #(
        .SETS(SETS)
    ) u_frames (
        .clk     (CLK),
        .rst     (RST),
        .rd_idx  (rd_idx),
        .rd_frame(fr),
        .we      (we),
        .wr_idx  (rd_idx),
        .wr_frame(wr_frame)
    );

    assign req     = dmemREN || dmemWEN;
    assign is_sc   = dmemWEN && datomic;
    assign sc_fail = is_sc && (!link_valid || link_addr != word_addr);
    assign hit     = fr.valid && (fr.tag == blk);
    assign miss    = req && !sc_fail && !hit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            armed        <= 1'b0;
            miss_pending <= 1'b0;
            hit_cnt      <= '0;
            link_valid   <= 1'b0;
            link_addr    <= '0;
            fill         <= '0;
            ptr          <= '0;
        end else begin
            state        <= state_n;
            armed        <= 1'b1;
            miss_pending <= miss_pending_n;
            hit_cnt      <= hit_cnt_n;
            link_valid   <= link_valid_n;
            link_addr    <= link_addr_n;
            fill         <= fill_n;
            ptr          <= ptr_n;
        end
    end

    always_comb begin
        state_n        = state;
        miss_pending_n = miss_pending;
        hit_cnt_n      = hit_cnt;
        link_valid_n   = link_valid;
        link_addr_n    = link_addr;
        fill_n         = fill;
        ptr_n          = ptr;
        we             = 1'b0;
        wr_frame       = fr;
        dhit           = 1'b0;
        dmemload       = '0;
        flushed        = 1'b0;
        dREN           = 1'b0;
        dWEN           = 1'b0;
        daddr          = '0;
        dstore         = '0;

        unique case (state)
            IDLE: begin
                // armed keeps the first post-reset cycle fully quiet
                if (armed) begin
                    if (req && sc_fail) begin
                        dhit = 1'b1;
                    end else if (req && hit) begin
                        dhit     = 1'b1;
                        dmemload = is_sc ? 32'd1 : fr.data[off];
                        if (dmemWEN) begin
                            we                 = 1'b1;
                            wr_frame.dirty     = 1'b1;
                            wr_frame.data[off] = dmemstore;
                            if (is_sc || word_addr == link_addr) begin
                                link_valid_n = 1'b0;
                            end
                        end else if (datomic) begin
                            link_valid_n = 1'b1;
                            link_addr_n  = word_addr;
                        end
                    end else if (miss) begin
                        miss_pending_n = 1'b1;
                        state_n = (fr.valid && fr.dirty) ? WB0 : FETCH0;
                    end
                    if (halt && !miss) begin
                        state_n = FLUSH;
                        ptr_n   = '0;
                    end
                end
            end
            WB0, FWB0: begin
                dWEN   = 1'b1;
                daddr  = {fr.tag, 1'b0, 2'b00};
                dstore = fr.data[0];
                if (!dwait) begin
                    state_n = (state == WB0) ? WB1 : FWB1;
                end
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {fr.tag, 1'b1, 2'b00};
                dstore = fr.data[1];
                if (!dwait) begin
                    state_n = FETCH0;
                end
            end
            FWB1: begin
                dWEN   = 1'b1;
                daddr  = {fr.tag, 1'b1, 2'b00};
                dstore = fr.data[1];
                if (!dwait) begin
                    we             = 1'b1;
                    wr_frame.dirty = 1'b0;
                    ptr_n          = ptr + PTR_W'(1);
                    state_n        = FLUSH;
                end
            end
            FETCH0: begin
                dREN  = 1'b1;
                daddr = {blk, 1'b0, 2'b00};
                if (!dwait) begin
                    fill_n  = dload;
                    state_n = FETCH1;
                end
            end
            FETCH1: begin
                dREN  = 1'b1;
                daddr = {blk, 1'b1, 2'b00};
                if (!dwait) begin
                    we               = 1'b1;
                    wr_frame.valid   = 1'b1;
                    wr_frame.dirty   = 1'b0;
                    wr_frame.tag     = blk;
                    wr_frame.data[0] = fill;
                    wr_frame.data[1] = dload;
                    state_n          = IDLE;
                end
            end
            FLUSH: begin
                if (ptr == PTR_W'(SETS)) begin
                    state_n = HITCNT;
                end else if (fr.valid && fr.dirty) begin
                    state_n = FWB0;
                end else begin
                    ptr_n = ptr + PTR_W'(1);
                end
            end
            HITCNT: begin
                dWEN   = 1'b1;
                daddr  = HIT_ADDR;
                dstore = hit_cnt;
                if (!dwait) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // the hit that retires a miss is not counted
        if (dhit) begin
            miss_pending_n = 1'b0;
            if (!miss_pending) begin
                hit_cnt_n = hit_cnt + 32'd1;
            end
        end
    end
endmodule
